// File: rtl/excp_commit_if.sv
// Commit-stage exception bus: per-pipe exception classification and payload,
// current CSR vectors, CSR update strobe/payload, flush and frontend redirect.
interface excp_commit_if;
    logic [1:0]        pipe_valid_i;
    logic [1:0]        excp_trigger_i;
    logic [1:0]        va_error_i;
    logic [1:0]        tlbrefill_i;
    logic [1:0]        tlbehi_update_i;
    logic [1:0]        ertn_i;
    logic [1:0][5:0]   ecode_i;
    logic [1:0][8:0]   esubcode_i;
    logic [1:0][31:0]  bad_va_i;
    logic [1:0][31:0]  pc_i;
    logic [31:0]       eentry_i;
    logic [31:0]       tlbrentry_i;
    logic [31:0]       era_i;
    logic              redirect_ready_i;

    logic [1:0]        commit_mask_o;
    logic              stall_o;
    logic              csr_wr_valid_o;
    logic [5:0]        csr_ecode_o;
    logic [8:0]        csr_esubcode_o;
    logic [31:0]       csr_era_o;
    logic [31:0]       csr_badv_o;
    logic [18:0]       csr_vppn_o;
    logic              csr_badv_we_o;
    logic              csr_tlbehi_we_o;
    logic              csr_tlbrefill_o;
    logic              csr_ertn_o;
    logic              flush_o;
    logic              redirect_valid_o;
    logic [31:0]       redirect_pc_o;

    modport master (
        output pipe_valid_i, excp_trigger_i, va_error_i, tlbrefill_i,
               tlbehi_update_i, ertn_i, ecode_i, esubcode_i, bad_va_i, pc_i,
               eentry_i, tlbrentry_i, era_i, redirect_ready_i,
        input  commit_mask_o, stall_o, csr_wr_valid_o, csr_ecode_o,
               csr_esubcode_o, csr_era_o, csr_badv_o, csr_vppn_o,
               csr_badv_we_o, csr_tlbehi_we_o, csr_tlbrefill_o, csr_ertn_o,
               flush_o, redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  pipe_valid_i, excp_trigger_i, va_error_i, tlbrefill_i,
               tlbehi_update_i, ertn_i, ecode_i, esubcode_i, bad_va_i, pc_i,
               eentry_i, tlbrentry_i, era_i, redirect_ready_i,
        output commit_mask_o, stall_o, csr_wr_valid_o, csr_ecode_o,
               csr_esubcode_o, csr_era_o, csr_badv_o, csr_vppn_o,
               csr_badv_we_o, csr_tlbehi_we_o, csr_tlbrefill_o, csr_ertn_o,
               flush_o, redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/excp_commit_ctrl.sv
// Exception / ERTN commit controller for a two-wide commit stage.
// Picks the oldest excepting pipe, gates retirement, then sequences a
// one-cycle CSR update, a FLUSH_CYCLES-long flush and a held frontend redirect.
module excp_commit_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    excp_commit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CSR_WR,
        FLUSH,
        REDIRECT
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  flush_cnt;

    logic [1:0]  ev;
    logic [1:0]  exc;
    logic        any_ev;
    logic        sel;
    logic        sel_exc;

    logic        lat_ertn;
    logic [5:0]  lat_ecode;
    logic [8:0]  lat_esub;
    logic [31:0] lat_pc;
    logic [31:0] lat_badv;
    logic        lat_va_err;
    logic        lat_tlbehi;
    logic        lat_tlbrefill;
    logic [31:0] lat_target;

    logic [1:0]  commit_mask;
    logic        stall;
    logic        csr_wr_valid;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esub;
    logic [31:0] csr_era;
    logic [31:0] csr_badv;
    logic [18:0] csr_vppn;
    logic        csr_badv_we;
    logic        csr_tlbehi_we;
    logic        csr_tlbrefill;
    logic        csr_ertn;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Per-pipe event decode and oldest-first selection (pipe 0 wins).
    always_comb begin
        ev      = bus.pipe_valid_i & (bus.excp_trigger_i | bus.ertn_i);
        exc     = bus.pipe_valid_i & bus.excp_trigger_i;
        any_ev  = |ev;
        sel     = ~ev[0];
        sel_exc = exc[sel];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing: IDLE -> CSR_WR -> FLUSH(xN) -> REDIRECT -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_ev) state_nxt = CSR_WR;
            CSR_WR:   state_nxt = FLUSH;
            FLUSH:    if (flush_cnt == '0) state_nxt = REDIRECT;
            REDIRECT: if (bus.redirect_ready_i) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Flush length counter, loaded on the CSR write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (state == CSR_WR) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (state == FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Capture the selected pipe's payload and redirect target on acceptance.
    // An exception outranks ERTN in the same pipe, so the ERTN flag is only
    // kept when the selected pipe is not excepting; TLB refill is likewise
    // only meaningful for an exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_ertn      <= 1'b0;
            lat_ecode     <= '0;
            lat_esub      <= '0;
            lat_pc        <= '0;
            lat_badv      <= '0;
            lat_va_err    <= 1'b0;
            lat_tlbehi    <= 1'b0;
            lat_tlbrefill <= 1'b0;
            lat_target    <= '0;
        end else if (state == IDLE && any_ev) begin
            lat_ertn      <= ~sel_exc;
            lat_ecode     <= sel_exc ? bus.ecode_i[sel]    : '0;
            lat_esub      <= sel_exc ? bus.esubcode_i[sel] : '0;
            lat_pc        <= sel_exc ? bus.pc_i[sel]       : '0;
            lat_badv      <= sel_exc ? bus.bad_va_i[sel]   : '0;
            lat_va_err    <= sel_exc & bus.va_error_i[sel];
            lat_tlbehi    <= sel_exc & bus.tlbehi_update_i[sel];
            lat_tlbrefill <= sel_exc & bus.tlbrefill_i[sel];
            if (sel_exc && bus.tlbrefill_i[sel]) begin
                lat_target <= bus.tlbrentry_i;
            end else if (!sel_exc) begin
                lat_target <= bus.era_i;
            end else begin
                lat_target <= bus.eentry_i;
            end
        end
    end

    // Output decode; every payload is zero outside its qualifying state.
    always_comb begin
        commit_mask    = '0;
        stall          = 1'b0;
        csr_wr_valid   = 1'b0;
        csr_ecode      = '0;
        csr_esub       = '0;
        csr_era        = '0;
        csr_badv       = '0;
        csr_vppn       = '0;
        csr_badv_we    = 1'b0;
        csr_tlbehi_we  = 1'b0;
        csr_tlbrefill  = 1'b0;
        csr_ertn       = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                stall = any_ev;
                if (!any_ev) begin
                    commit_mask = bus.pipe_valid_i;
                end else if (ev[0]) begin
                    commit_mask = exc[0] ? 2'b00 : 2'b01;
                end else begin
                    commit_mask = exc[1] ? (bus.pipe_valid_i & 2'b01) : bus.pipe_valid_i;
                end
            end
            CSR_WR: begin
                stall        = 1'b1;
                csr_wr_valid = 1'b1;
                if (lat_ertn) begin
                    csr_ertn = 1'b1;
                end else begin
                    csr_ecode     = lat_ecode;
                    csr_esub      = lat_esub;
                    csr_era       = lat_pc;
                    csr_badv      = lat_badv;
                    csr_vppn      = lat_badv[31:13];
                    csr_badv_we   = lat_va_err;
                    csr_tlbehi_we = lat_tlbehi;
                    csr_tlbrefill = lat_tlbrefill;
                end
            end
            FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
            end
            REDIRECT: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = lat_target;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

    assign bus.commit_mask_o    = commit_mask;
    assign bus.stall_o          = stall;
    assign bus.csr_wr_valid_o   = csr_wr_valid;
    assign bus.csr_ecode_o      = csr_ecode;
    assign bus.csr_esubcode_o   = csr_esub;
    assign bus.csr_era_o        = csr_era;
    assign bus.csr_badv_o       = csr_badv;
    assign bus.csr_vppn_o       = csr_vppn;
    assign bus.csr_badv_we_o    = csr_badv_we;
    assign bus.csr_tlbehi_we_o  = csr_tlbehi_we;
    assign bus.csr_tlbrefill_o  = csr_tlbrefill;
    assign bus.csr_ertn_o       = csr_ertn;
    assign bus.flush_o          = flush;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = redirect_pc;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Bench for excp_commit_ctrl: directed scenarios plus randomized transactions
// checked against a rule-level reference model.
module tb_excp_commit_ctrl;

    localparam int FC = 2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    excp_commit_if bus ();

    excp_commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       valid;
        logic [1:0]       trig;
        logic [1:0]       vaerr;
        logic [1:0]       tlbr;
        logic [1:0]       tlbehi;
        logic [1:0]       ertn;
        logic [1:0][5:0]  ecode;
        logic [1:0][8:0]  esub;
        logic [1:0][31:0] badva;
        logic [1:0][31:0] pc;
        logic [31:0]      eentry;
        logic [31:0]      tlbrentry;
        logic [31:0]      era;
    } stim_t;

    typedef struct packed {
        logic [1:0]  mask;
        logic        stall;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] era;
        logic [31:0] badv;
        logic [18:0] vppn;
        logic        badv_we;
        logic        tlbehi_we;
        logic        tlbrefill;
        logic        ertn;
        logic [31:0] target;
    } exp_t;

    typedef struct packed {
        logic [1:0]  mask;
        logic        stall;
        logic [1:0]  mask1;
        logic        stall1;
        logic        wr_valid;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] era;
        logic [31:0] badv;
        logic [18:0] vppn;
        logic        badv_we;
        logic        tlbehi_we;
        logic        tlbrefill;
        logic        ertn;
        int          flush_cnt;
        int          redir_off;
        logic [31:0] redir_pc;
        logic        stable;
        logic        quiet;
        logic        timeout;
        logic        after_valid;
        logic        after_stall;
        logic [1:0]  after_mask;
        logic [1:0]  after_pv;
    } obs_t;

    // Reference model: what the commit stage must do for one cycle of inputs.
    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit   has0;
        bit   has1;
        int   p;
        e    = '0;
        has0 = s.valid[0] && (s.trig[0] || s.ertn[0]);
        has1 = s.valid[1] && (s.trig[1] || s.ertn[1]);
        if (!has0 && !has1) begin
            e.mask = s.valid;
            return e;
        end
        e.stall = 1'b1;
        p = has0 ? 0 : 1;
        if (p == 0) e.mask = s.trig[0] ? 2'b00 : 2'b01;
        else        e.mask = s.trig[1] ? (s.valid & 2'b01) : s.valid;
        if (s.trig[p]) begin
            e.ecode     = s.ecode[p];
            e.esub      = s.esub[p];
            e.era       = s.pc[p];
            e.badv      = s.badva[p];
            e.vppn      = 19'(s.badva[p] >> 13);
            e.badv_we   = s.vaerr[p];
            e.tlbehi_we = s.tlbehi[p];
            e.tlbrefill = s.tlbr[p];
            e.target    = s.tlbr[p] ? s.tlbrentry : s.eentry;
        end else begin
            e.ertn   = 1'b1;
            e.target = s.era;
        end
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid     = 2'($urandom);
        s.trig      = 2'($urandom);
        s.vaerr     = 2'($urandom);
        s.tlbr      = 2'($urandom);
        s.tlbehi    = 2'($urandom);
        s.ertn      = 2'($urandom);
        s.ecode     = 12'($urandom);
        s.esub      = 18'($urandom);
        s.badva     = {$urandom, $urandom};
        s.pc        = {$urandom, $urandom};
        s.eentry    = $urandom;
        s.tlbrentry = $urandom;
        s.era       = $urandom;
        return s;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s      = rand_stim();
        s.trig = 2'b00;
        s.ertn = 2'b00;
        return s;
    endfunction

    function automatic bit csr_quiet();
        return (bus.csr_wr_valid_o == 1'b0) && (bus.csr_ecode_o == '0) &&
               (bus.csr_esubcode_o == '0) && (bus.csr_era_o == '0) &&
               (bus.csr_badv_o == '0) && (bus.csr_vppn_o == '0) &&
               (bus.csr_badv_we_o == 1'b0) && (bus.csr_tlbehi_we_o == 1'b0) &&
               (bus.csr_tlbrefill_o == 1'b0) && (bus.csr_ertn_o == 1'b0);
    endfunction

    task automatic apply(input stim_t s);
        bus.pipe_valid_i    = s.valid;
        bus.excp_trigger_i  = s.trig;
        bus.va_error_i      = s.vaerr;
        bus.tlbrefill_i     = s.tlbr;
        bus.tlbehi_update_i = s.tlbehi;
        bus.ertn_i          = s.ertn;
        bus.ecode_i         = s.ecode;
        bus.esubcode_i      = s.esub;
        bus.bad_va_i        = s.badva;
        bus.pc_i            = s.pc;
        bus.eentry_i        = s.eentry;
        bus.tlbrentry_i     = s.tlbrentry;
        bus.era_i           = s.era;
    endtask

    // Leaves the bench at a negedge with reset released and idle inputs.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_ready_i = 1'b0;
        apply(idle_stim());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one event at the current negedge and records the whole sequence.
    // Unrelated random traffic (including new events) is driven after the
    // event cycle. Returns at the negedge after the redirect handshake.
    task automatic run_event(input stim_t s, input int ready_delay, output obs_t o);
        int c;
        int waits;
        o = '0;
        o.stable = 1'b1;
        o.quiet  = 1'b1;
        bus.redirect_ready_i = 1'b0;
        apply(s);
        #1;
        o.mask  = bus.commit_mask_o;
        o.stall = bus.stall_o;
        @(posedge clk); @(negedge clk);
        apply(rand_stim());
        #1;
        o.mask1     = bus.commit_mask_o;
        o.stall1    = bus.stall_o;
        o.wr_valid  = bus.csr_wr_valid_o;
        o.ecode     = bus.csr_ecode_o;
        o.esub      = bus.csr_esubcode_o;
        o.era       = bus.csr_era_o;
        o.badv      = bus.csr_badv_o;
        o.vppn      = bus.csr_vppn_o;
        o.badv_we   = bus.csr_badv_we_o;
        o.tlbehi_we = bus.csr_tlbehi_we_o;
        o.tlbrefill = bus.csr_tlbrefill_o;
        o.ertn      = bus.csr_ertn_o;
        c = 1;
        forever begin
            @(posedge clk); @(negedge clk);
            apply(rand_stim());
            #1;
            c++;
            if (bus.redirect_valid_o) break;
            if (bus.flush_o) o.flush_cnt++;
            if (!csr_quiet() || bus.redirect_pc_o != '0 || bus.stall_o !== 1'b1 || bus.commit_mask_o !== 2'b00)
                o.quiet = 1'b0;
            if (c > 40) begin
                o.timeout = 1'b1;
                return;
            end
        end
        o.redir_off = c;
        o.redir_pc  = bus.redirect_pc_o;
        if (bus.flush_o || !csr_quiet()) o.stable = 1'b0;
        waits = 0;
        while (waits < ready_delay) begin
            @(posedge clk); @(negedge clk);
            apply(rand_stim());
            #1;
            if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== o.redir_pc ||
                bus.stall_o !== 1'b1 || bus.commit_mask_o !== 2'b00 ||
                bus.flush_o || !csr_quiet())
                o.stable = 1'b0;
            waits++;
        end
        bus.redirect_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.redirect_ready_i = 1'b0;
        apply(idle_stim());
        #1;
        o.after_valid = bus.redirect_valid_o;
        o.after_stall = bus.stall_o;
        o.after_mask  = bus.commit_mask_o;
        o.after_pv    = bus.pipe_valid_i;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        rst_n = 1'b0;
        bus.redirect_ready_i = 1'b0;
        s = idle_stim();
        apply(s);
        #1;
        vectors++; if ({bus.flush_o, bus.csr_wr_valid_o, bus.redirect_valid_o} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes got %b exp 000", {bus.flush_o, bus.csr_wr_valid_o, bus.redirect_valid_o}); end
        vectors++; if (bus.redirect_pc_o !== 32'h0 || !csr_quiet()) begin miscompares++; $display("FAIL reset_payload got pc %h quiet %0d exp 0/1", bus.redirect_pc_o, csr_quiet()); end
        vectors++; if (bus.commit_mask_o !== s.valid) begin miscompares++; $display("FAIL reset_mask got %b exp %b", bus.commit_mask_o, s.valid); end
        vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", bus.stall_o); end
        s = rand_stim();
        s.valid = 2'b11;
        s.trig  = 2'b01;
        e = predict(s);
        apply(s);
        #1;
        vectors++; if (bus.stall_o !== e.stall) begin miscompares++; $display("FAIL reset_evt_stall got %b exp %b", bus.stall_o, e.stall); end
        vectors++; if (bus.commit_mask_o !== e.mask) begin miscompares++; $display("FAIL reset_evt_mask got %b exp %b", bus.commit_mask_o, e.mask); end
        @(posedge clk); @(negedge clk); #1;
        vectors++; if (!csr_quiet() || bus.flush_o !== 1'b0) begin miscompares++; $display("FAIL reset_hold got wr %b flush %b exp 0 0", bus.csr_wr_valid_o, bus.flush_o); end
        do_reset();
    endtask

    task automatic test_pipe1_va();
        stim_t s;
        obs_t  o;
        do_reset();
        s = idle_stim();
        s.valid = 2'b11; s.trig = 2'b10; s.vaerr = 2'b10; s.tlbr = 2'b00;
        s.ecode[1] = 6'h08; s.badva[1] = 32'h1234_6000; s.eentry = 32'h1C00_8000;
        run_event(s, 0, o);
        vectors++; if (o.timeout !== 1'b0) begin miscompares++; $display("FAIL p1va_timeout got %b exp 0", o.timeout); end
        vectors++; if (o.mask !== 2'b01) begin miscompares++; $display("FAIL p1va_mask got %b exp 01", o.mask); end
        vectors++; if (o.badv_we !== 1'b1 || o.ecode !== 6'h08) begin miscompares++; $display("FAIL p1va_csr got we %b ecode %h exp 1 08", o.badv_we, o.ecode); end
        vectors++; if (o.vppn !== 19'h091A3) begin miscompares++; $display("FAIL p1va_vppn got %h exp 091a3", o.vppn); end
        vectors++; if (o.redir_pc !== 32'h1C00_8000) begin miscompares++; $display("FAIL p1va_target got %h exp 1c008000", o.redir_pc); end
    endtask

    task automatic test_both_pipes();
        stim_t s;
        obs_t  o;
        do_reset();
        s = rand_stim();
        s.valid = 2'b11; s.trig = 2'b11; s.tlbr = 2'b00;
        s.pc[0] = 32'h1C00_0100; s.pc[1] = 32'h1C00_0104;
        s.ecode[0] = 6'h01; s.ecode[1] = 6'h02;
        run_event(s, 0, o);
        vectors++; if (o.mask !== 2'b00) begin miscompares++; $display("FAIL both_mask got %b exp 00", o.mask); end
        vectors++; if (o.era !== 32'h1C00_0100) begin miscompares++; $display("FAIL both_era got %h exp 1c000100", o.era); end
        vectors++; if (o.ecode !== 6'h01) begin miscompares++; $display("FAIL both_ecode got %h exp 01", o.ecode); end
    endtask

    task automatic test_tlbrefill();
        stim_t s;
        obs_t  o;
        do_reset();
        s = rand_stim();
        s.valid = 2'b01; s.trig = 2'b01; s.tlbr = 2'b01; s.tlbehi = 2'b01;
        s.tlbrentry = 32'h0000_8000;
        run_event(s, 0, o);
        vectors++; if (o.flush_cnt !== FC) begin miscompares++; $display("FAIL tlbr_flush got %0d exp %0d", o.flush_cnt, FC); end
        vectors++; if (o.redir_off !== 2 + FC) begin miscompares++; $display("FAIL tlbr_latency got %0d exp %0d", o.redir_off, 2 + FC); end
        vectors++; if (o.redir_pc !== 32'h0000_8000) begin miscompares++; $display("FAIL tlbr_target got %h exp 00008000", o.redir_pc); end
        vectors++; if (o.tlbehi_we !== 1'b1 || o.tlbrefill !== 1'b1) begin miscompares++; $display("FAIL tlbr_qual got ehi %b refill %b exp 1 1", o.tlbehi_we, o.tlbrefill); end
    endtask

    task automatic test_ertn();
        stim_t s;
        obs_t  o;
        do_reset();
        s = rand_stim();
        s.valid = 2'b11; s.trig = 2'b00; s.ertn = 2'b01;
        s.era = 32'h1C00_2000;
        run_event(s, 0, o);
        vectors++; if (o.mask !== 2'b01) begin miscompares++; $display("FAIL ertn_mask got %b exp 01", o.mask); end
        vectors++; if (o.ertn !== 1'b1 || o.wr_valid !== 1'b1) begin miscompares++; $display("FAIL ertn_flag got ertn %b wr %b exp 1 1", o.ertn, o.wr_valid); end
        vectors++; if ({o.badv_we, o.tlbehi_we, o.tlbrefill} !== 3'b000) begin miscompares++; $display("FAIL ertn_qual got %b exp 000", {o.badv_we, o.tlbehi_we, o.tlbrefill}); end
        vectors++; if (o.redir_pc !== 32'h1C00_2000) begin miscompares++; $display("FAIL ertn_target got %h exp 1c002000", o.redir_pc); end
    endtask

    task automatic test_redirect_wait();
        stim_t s;
        exp_t  e;
        obs_t  o;
        do_reset();
        s = rand_stim();
        s.valid = 2'b10; s.trig = 2'b10;
        e = predict(s);
        run_event(s, 5, o);
        vectors++; if (o.stable !== 1'b1) begin miscompares++; $display("FAIL wait_stable got %b exp 1", o.stable); end
        vectors++; if (o.redir_pc !== e.target) begin miscompares++; $display("FAIL wait_target got %h exp %h", o.redir_pc, e.target); end
        vectors++; if (o.after_valid !== 1'b0 || o.after_stall !== 1'b0) begin miscompares++; $display("FAIL wait_release got v %b s %b exp 0 0", o.after_valid, o.after_stall); end
    endtask

    task automatic test_reset_mid_flush();
        stim_t s;
        bit    seen;
        do_reset();
        s = rand_stim();
        s.valid = 2'b01; s.trig = 2'b01;
        apply(s);
        @(posedge clk); @(negedge clk);
        apply(rand_stim());
        @(posedge clk); @(negedge clk);
        s = idle_stim();
        apply(s);
        #1;
        vectors++; if (bus.flush_o !== 1'b1) begin miscompares++; $display("FAIL rstf_pre got flush %b exp 1", bus.flush_o); end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.flush_o, bus.redirect_valid_o, bus.stall_o} !== 3'b000 || !csr_quiet() || bus.redirect_pc_o !== 32'h0) begin miscompares++; $display("FAIL rstf_outputs got flush %b rv %b stall %b exp 0 0 0", bus.flush_o, bus.redirect_valid_o, bus.stall_o); end
        vectors++; if (bus.commit_mask_o !== s.valid) begin miscompares++; $display("FAIL rstf_mask got %b exp %b", bus.commit_mask_o, s.valid); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        bus.redirect_ready_i = 1'b1;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            apply(idle_stim());
            #1;
            if (bus.redirect_valid_o || bus.flush_o || !csr_quiet()) seen = 1'b1;
        end
        bus.redirect_ready_i = 1'b0;
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstf_resume got activity %b exp 0", seen); end
    endtask

    task automatic test_back_to_back();
        stim_t s1;
        stim_t s2;
        exp_t  e2;
        obs_t  o1;
        obs_t  o2;
        do_reset();
        s1 = rand_stim();
        s1.valid = 2'b01; s1.trig = 2'b01;
        s2 = rand_stim();
        s2.valid = 2'b10; s2.trig = 2'b00; s2.ertn = 2'b10;
        e2 = predict(s2);
        run_event(s1, 0, o1);
        run_event(s2, 1, o2);
        vectors++; if (o2.mask !== e2.mask || o2.stall !== 1'b1) begin miscompares++; $display("FAIL b2b_mask got %b/%b exp %b/1", o2.mask, o2.stall, e2.mask); end
        vectors++; if (o2.wr_valid !== 1'b1 || o2.ertn !== 1'b1) begin miscompares++; $display("FAIL b2b_csr got wr %b ertn %b exp 1 1", o2.wr_valid, o2.ertn); end
        vectors++; if (o2.redir_pc !== e2.target) begin miscompares++; $display("FAIL b2b_target got %h exp %h", o2.redir_pc, e2.target); end
    endtask

    task automatic test_random();
        stim_t s;
        exp_t  e;
        obs_t  o;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            s = rand_stim();
            e = predict(s);
            if (!e.stall) begin
                apply(s);
                #1;
                vectors++; if (bus.commit_mask_o !== e.mask || bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_noevt got %b/%b exp %b/0", i, bus.commit_mask_o, bus.stall_o, e.mask); end
                @(posedge clk); @(negedge clk);
                continue;
            end
            run_event(s, int'($urandom_range(0, 3)), o);
            vectors++; if (o.timeout !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_timeout got 1 exp 0", i); do_reset(); continue; end
            vectors++; if (o.mask !== e.mask || o.stall !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_mask got %b/%b exp %b/1", i, o.mask, o.stall, e.mask); end
            vectors++; if (o.mask1 !== 2'b00 || o.stall1 !== 1'b1 || o.wr_valid !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_csrcyc got m %b s %b wr %b exp 00 1 1", i, o.mask1, o.stall1, o.wr_valid); end
            vectors++; if ({o.ertn, o.badv_we, o.tlbehi_we, o.tlbrefill} !== {e.ertn, e.badv_we, e.tlbehi_we, e.tlbrefill}) begin miscompares++; $display("FAIL rnd%0d_qual got %b exp %b", i, {o.ertn, o.badv_we, o.tlbehi_we, o.tlbrefill}, {e.ertn, e.badv_we, e.tlbehi_we, e.tlbrefill}); end
            if (!e.ertn) begin
                vectors++; if ({o.ecode, o.esub, o.era, o.badv, o.vppn} !== {e.ecode, e.esub, e.era, e.badv, e.vppn}) begin miscompares++; $display("FAIL rnd%0d_payload got %h %h %h %h %h exp %h %h %h %h %h", i, o.ecode, o.esub, o.era, o.badv, o.vppn, e.ecode, e.esub, e.era, e.badv, e.vppn); end
            end
            vectors++; if (o.flush_cnt !== FC || o.redir_off !== 2 + FC) begin miscompares++; $display("FAIL rnd%0d_timing got flush %0d redir %0d exp %0d %0d", i, o.flush_cnt, o.redir_off, FC, 2 + FC); end
            vectors++; if (o.redir_pc !== e.target) begin miscompares++; $display("FAIL rnd%0d_target got %h exp %h", i, o.redir_pc, e.target); end
            vectors++; if (o.stable !== 1'b1 || o.quiet !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_hold got stable %b quiet %b exp 1 1", i, o.stable, o.quiet); end
            vectors++; if (o.after_valid !== 1'b0 || o.after_stall !== 1'b0 || o.after_mask !== o.after_pv) begin miscompares++; $display("FAIL rnd%0d_idle got v %b s %b m %b exp 0 0 %b", i, o.after_valid, o.after_stall, o.after_mask, o.after_pv); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.redirect_ready_i = 1'b0;
        apply(idle_stim());
        @(negedge clk);
        test_reset();
        test_pipe1_va();
        test_both_pipes();
        test_tlbrefill();
        test_ertn();
        test_redirect_wait();
        test_reset_mid_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
